// File: rtl/bp_me_cache_cmd_arbiter.sv
// Round-robin arbiter that shares one cache-converter command port among num_req_p requesters.
// Responses return in command order and are steered to their requester by an in-order source-ID FIFO.
module bp_me_cache_cmd_arbiter #(
  parameter int num_req_p     = 2,
  parameter int msg_width_p   = 600,
  parameter int outstanding_p = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] mem_cmd_i,
  input  logic [num_req_p-1:0]             mem_cmd_v_i,
  output logic [num_req_p-1:0]             mem_cmd_ready_and_o,
  output logic [msg_width_p-1:0]           mem_cmd_o,
  output logic                             mem_cmd_v_o,
  input  logic                             mem_cmd_ready_and_i,
  input  logic [msg_width_p-1:0]           mem_resp_i,
  input  logic                             mem_resp_v_i,
  output logic                             mem_resp_yumi_o,
  output logic [msg_width_p-1:0]           mem_resp_o,
  output logic [num_req_p-1:0]             mem_resp_v_o,
  input  logic [num_req_p-1:0]             mem_resp_yumi_i
);
  localparam int lg_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
  localparam int lg_out_lp = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_w_lp  = $clog2(outstanding_p + 1);

  typedef enum logic {IDLE_S = 1'b0, LOCKED_S = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic [lg_req_lp-1:0]   lock_id_q, lock_id_d;
  logic [lg_req_lp-1:0]   rr_ptr_q, rr_grant_s, rr_idx_s, grant_s, head_s;
  logic                   rr_found_s;
  logic [lg_req_lp-1:0]   fifo_mem_q [outstanding_p];
  logic [lg_out_lp-1:0]   wptr_q, rptr_q;
  logic [cnt_w_lp-1:0]    count_q;
  logic                   fifo_full_s, fifo_empty_s, cmd_v_s, fire_s, resp_ok_s, pop_s;
  logic [msg_width_p-1:0] cmd_arr_s [num_req_p];

  function automatic logic [lg_out_lp-1:0] ptr_inc(input logic [lg_out_lp-1:0] p);
    return (p == lg_out_lp'(outstanding_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full_s  = (count_q == cnt_w_lp'(outstanding_p));
  assign fifo_empty_s = (count_q == '0);
  assign head_s       = fifo_mem_q[rptr_q];
  assign resp_ok_s    = mem_resp_v_i & ~fifo_empty_s;
  assign pop_s        = resp_ok_s & mem_resp_yumi_i[head_s];

  // First valid requester at or after rr_ptr, wrapping modulo num_req_p
  always_comb begin
    rr_grant_s = rr_ptr_q;
    rr_idx_s   = rr_ptr_q;
    rr_found_s = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (!rr_found_s && mem_cmd_v_i[rr_idx_s]) begin
        rr_found_s = 1'b1;
        rr_grant_s = rr_idx_s;
      end else begin
        rr_found_s = rr_found_s;
      end
      rr_idx_s = (rr_idx_s == lg_req_lp'(num_req_p - 1)) ? '0 : rr_idx_s + 1'b1;
    end
  end

  // Command-side state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE_S;
      lock_id_q <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
    end
  end

  // Lock the grant once offered and not accepted; release on fire
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      IDLE_S: begin
        if (cmd_v_s && !mem_cmd_ready_and_i) begin
          state_d   = LOCKED_S;
          lock_id_d = grant_s;
        end else begin
          state_d   = IDLE_S;
        end
      end
      LOCKED_S: begin
        if (fire_s) state_d = IDLE_S;
        else        state_d = LOCKED_S;
      end
      default: state_d = IDLE_S;
    endcase
  end

  // Grant and command valid; a full FIFO blocks new grants even if it pops this cycle
  always_comb begin
    grant_s = rr_grant_s;
    cmd_v_s = 1'b0;
    case (state_q)
      IDLE_S: begin
        grant_s = rr_grant_s;
        cmd_v_s = (|mem_cmd_v_i) & ~fifo_full_s;
      end
      LOCKED_S: begin
        grant_s = lock_id_q;
        cmd_v_s = 1'b1;
      end
      default: begin
        grant_s = rr_grant_s;
        cmd_v_s = 1'b0;
      end
    endcase
    fire_s = cmd_v_s & mem_cmd_ready_and_i;
  end

  // Round-robin pointer moves past the requester that just fired
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_q <= '0;
    end else if (fire_s) begin
      rr_ptr_q <= (grant_s == lg_req_lp'(num_req_p - 1)) ? '0 : grant_s + 1'b1;
    end else begin
      rr_ptr_q <= rr_ptr_q;
    end
  end

  // In-order source-ID FIFO: push on command fire, pop on response consume
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < outstanding_p; i++) fifo_mem_q[i] <= '0;
    end else begin
      if (fire_s) begin
        fifo_mem_q[wptr_q] <= grant_s;
        wptr_q             <= ptr_inc(wptr_q);
      end else begin
        wptr_q <= wptr_q;
      end
      if (pop_s) rptr_q <= ptr_inc(rptr_q);
      else       rptr_q <= rptr_q;
      case ({fire_s, pop_s})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Outputs are forced to zero for the whole time reset is held
  for (genvar r = 0; r < num_req_p; r++) begin : g_req
    assign cmd_arr_s[r]           = mem_cmd_i[r*msg_width_p +: msg_width_p];
    assign mem_cmd_ready_and_o[r] = reset_n_i & fire_s & (grant_s == lg_req_lp'(r));
    assign mem_resp_v_o[r]        = reset_n_i & resp_ok_s & (head_s == lg_req_lp'(r));
  end

  assign mem_cmd_o       = reset_n_i ? cmd_arr_s[grant_s] : '0;
  assign mem_cmd_v_o     = reset_n_i & cmd_v_s;
  assign mem_resp_o      = reset_n_i ? mem_resp_i : '0;
  assign mem_resp_yumi_o = reset_n_i & pop_s;

  bp_me_cache_cmd_arbiter_chk #(
    .num_req_p(num_req_p),
    .lg_req_p (lg_req_lp)
  ) u_chk (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .locked_i       (state_q == LOCKED_S),
    .lock_id_i      (lock_id_q),
    .mem_cmd_v_i    (mem_cmd_v_i),
    .mem_resp_v_i   (mem_resp_v_i),
    .fifo_empty_i   (fifo_empty_s),
    .mem_resp_v_o   (mem_resp_v_o),
    .mem_resp_yumi_i(mem_resp_yumi_i)
  );
endmodule

// Protocol checks on the requester and converter sides of the arbiter.
module bp_me_cache_cmd_arbiter_chk #(
  parameter int num_req_p = 2,
  parameter int lg_req_p  = 1
) (
  input logic                 clk_i,
  input logic                 reset_n_i,
  input logic                 locked_i,
  input logic [lg_req_p-1:0]  lock_id_i,
  input logic [num_req_p-1:0] mem_cmd_v_i,
  input logic                 mem_resp_v_i,
  input logic                 fifo_empty_i,
  input logic [num_req_p-1:0] mem_resp_v_o,
  input logic [num_req_p-1:0] mem_resp_yumi_i
);
  a_resp_when_empty: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    mem_resp_v_i |-> !fifo_empty_i)
    else $error("response arrived with no outstanding command");

  a_yumi_owner: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (mem_resp_yumi_i & ~mem_resp_v_o) == '0)
    else $warning("yumi raised by a port with no response pending");

  a_lock_hold: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    locked_i |-> mem_cmd_v_i[lock_id_i])
    else $error("locked requester dropped valid before acceptance");
endmodule
